// File: rtl/busmem_pkg.sv
// busmem_pkg: shared definitions for the Unibus memory slave.
//   - bus_state_e : bus-side FSM states
//   - IDENT       : value returned by ARM register 0
//   - C_*         : Unibus c-code (cycle type) encodings
//   - DESKEW_LAST : final deskew count before the address is decoded
package busmem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DESKEW = 3'd1,
    ST_ACCESS = 3'd2,
    ST_REPLY  = 3'd3,
    ST_HOLD   = 3'd4
  } bus_state_e;

  localparam logic [31:0] IDENT       = 32'h424D2003;
  localparam logic [31:0] UNMAPPED    = 32'hDEADBEEF;
  localparam logic [1:0]  C_DATI      = 2'b00;
  localparam logic [1:0]  C_DATIP     = 2'b01;
  localparam logic [1:0]  C_DATO      = 2'b10;
  localparam logic [1:0]  C_DATOB     = 2'b11;
  localparam logic [3:0]  DESKEW_LAST = 4'd15;
  localparam logic [4:0]  IOPAGE_BASE = 5'o37;

  // DATI and DATIP both read; DATO and DATOB both write.
  function automatic logic is_read(input logic [1:0] c);
    return (c == C_DATI) || (c == C_DATIP);
  endfunction

  // Byte lanes written by a bus write cycle; a0 selects the lane for DATOB.
  function automatic logic [1:0] write_lanes(input logic [1:0] c, input logic a0);
    logic [1:0] lanes;
    case (c)
      C_DATO:  lanes = 2'b11;
      C_DATOB: lanes = a0 ? 2'b10 : 2'b01;
      default: lanes = 2'b00;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/busmem_ram.sv
// busmem_ram: 4096 x 16 single-port RAM, synchronous read (one clock),
// read-first, with per-byte write enables.
//   clk_i   : clock
//   en_i    : port enable (read and/or write this clock)
//   we_i    : byte write enables, [1] = high byte, [0] = low byte
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : registered read data (old contents on a write)
module busmem_ram (
  input  logic        clk_i,
  input  logic        en_i,
  input  logic [1:0]  we_i,
  input  logic [11:0] addr_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o
);

  logic [15:0] mem_q [4096];

  // Single shared port: byte-lane writes plus registered read.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
      if (we_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
      rdata_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/busmem.sv
// busmem: Unibus memory slave exposing an 8KB window of a 4096x16 RAM,
// with an ARM-side register file for configuration, statistics and
// direct RAM access.
//   CLOCK, RESET         : clock, synchronous active-high reset
//   armwrite/waddr/wdata : ARM register write port
//   armraddr/armrdata    : ARM register read port (combinational)
//   a_in_h,c_in_h,d_in_h : Unibus address, cycle type, write data
//   msyn_in_h, init_in_h : Unibus master sync and bus init
//   d_out_h, ssyn_out_h  : Unibus read data and slave sync (registered)
module busmem
  import busmem_pkg::*;
(
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        armwrite,
  input  logic [2:0]  armwaddr,
  input  logic [31:0] armwdata,
  input  logic [2:0]  armraddr,
  output logic [31:0] armrdata,
  input  logic [17:0] a_in_h,
  input  logic [1:0]  c_in_h,
  input  logic [15:0] d_in_h,
  input  logic        msyn_in_h,
  input  logic        init_in_h,
  output logic [15:0] d_out_h,
  output logic        ssyn_out_h
);

  bus_state_e  state_q;
  logic [3:0]  cnt_q;
  logic [15:0] d_out_q;
  logic        ssyn_q;
  logic [15:0] rdcount_q, wrcount_q;
  logic        enable_q;
  logic [4:0]  base_q;
  logic [11:0] armaddr_q;
  logic [15:0] armdata_q;
  logic        busy_q, req_wr_q, cap_q;

  logic        ram_en_s;
  logic [1:0]  ram_we_s;
  logic [11:0] ram_addr_s;
  logic [15:0] ram_wdata_s, ram_rdata_s;
  logic        arm_issue_s, match_s, cnt_clear_s;
  logic        unused_bits_s;

  assign unused_bits_s = ^armwdata[29:28];
  assign d_out_h    = d_out_q;
  assign ssyn_out_h = ssyn_q;

  // The ARM side may touch the RAM whenever the bus is not in ACCESS; a
  // pending read capture blocks a second issue until its data is taken.
  assign arm_issue_s = busy_q & ~cap_q & (state_q != ST_ACCESS);
  assign match_s     = enable_q & (a_in_h[17:13] == base_q) & (base_q != IOPAGE_BASE);
  assign cnt_clear_s = armwrite & (armwaddr == 3'd2);

  // RAM port arbitration: bus in ACCESS, otherwise a pending ARM request.
  always_comb begin
    ram_en_s    = 1'b0;
    ram_we_s    = 2'b00;
    ram_addr_s  = a_in_h[12:1];
    ram_wdata_s = d_in_h;
    if (state_q == ST_ACCESS) begin
      ram_en_s = 1'b1;
      // bus init during ACCESS aborts the write
      ram_we_s = init_in_h ? 2'b00 : write_lanes(c_in_h, a_in_h[0]);
    end else if (arm_issue_s) begin
      ram_en_s    = 1'b1;
      ram_we_s    = req_wr_q ? 2'b11 : 2'b00;
      ram_addr_s  = armaddr_q;
      ram_wdata_s = armdata_q;
    end else begin
      ram_en_s = 1'b0;
    end
  end

  busmem_ram u_ram (
    .clk_i   (CLOCK),
    .en_i    (ram_en_s),
    .we_i    (ram_we_s),
    .addr_i  (ram_addr_s),
    .wdata_i (ram_wdata_s),
    .rdata_o (ram_rdata_s)
  );

  // ARM register read mux.
  always_comb begin
    case (armraddr)
      3'd0:    armrdata = IDENT;
      3'd1:    armrdata = {enable_q, 13'd0, base_q, 13'd0};
      3'd2:    armrdata = {wrcount_q, rdcount_q};
      3'd3:    armrdata = {busy_q, 3'b000, armaddr_q, armdata_q};
      default: armrdata = UNMAPPED;
    endcase
  end

  // ARM configuration and request registers; untouched by bus init.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      enable_q  <= 1'b0;
      base_q    <= 5'd0;
      armaddr_q <= 12'd0;
      armdata_q <= 16'd0;
      busy_q    <= 1'b0;
      req_wr_q  <= 1'b0;
      cap_q     <= 1'b0;
    end else begin
      if (armwrite && (armwaddr == 3'd1)) begin
        enable_q <= armwdata[31];
        base_q   <= armwdata[17:13];
      end
      if (cap_q) begin
        armdata_q <= ram_rdata_s;
        busy_q    <= 1'b0;
        cap_q     <= 1'b0;
      end else if (arm_issue_s) begin
        if (req_wr_q) busy_q <= 1'b0;
        else          cap_q  <= 1'b1;
      end
      // busy_q low implies no issue/capture is active this clock
      if (armwrite && (armwaddr == 3'd3) && !busy_q) begin
        armaddr_q <= armwdata[27:16];
        armdata_q <= armwdata[15:0];
        req_wr_q  <= armwdata[31];
        busy_q    <= armwdata[31] | armwdata[30];
      end
    end
  end

  // Unibus slave FSM with registered outputs and cycle counters.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      d_out_q   <= 16'd0;
      ssyn_q    <= 1'b0;
      rdcount_q <= 16'd0;
      wrcount_q <= 16'd0;
    end else begin
      if (cnt_clear_s) begin
        rdcount_q <= 16'd0;
        wrcount_q <= 16'd0;
      end else if ((state_q == ST_REPLY) && !init_in_h) begin
        if (is_read(c_in_h)) rdcount_q <= rdcount_q + 16'd1;
        else                 wrcount_q <= wrcount_q + 16'd1;
      end
      if (init_in_h) begin
        state_q <= ST_IDLE;
        cnt_q   <= 4'd0;
        d_out_q <= 16'd0;
        ssyn_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            cnt_q <= 4'd0;
            if (msyn_in_h) state_q <= ST_DESKEW;
          end
          ST_DESKEW: begin
            if (!msyn_in_h)                  state_q <= ST_IDLE;
            else if (cnt_q != DESKEW_LAST)   cnt_q   <= cnt_q + 4'd1;
            else if (match_s)                state_q <= ST_ACCESS;
            else                             state_q <= ST_HOLD;
          end
          ST_ACCESS: state_q <= ST_REPLY;
          ST_REPLY: begin
            ssyn_q  <= 1'b1;
            d_out_q <= is_read(c_in_h) ? ram_rdata_s : 16'd0;
            state_q <= ST_HOLD;
          end
          ST_HOLD: begin
            if (!msyn_in_h) begin
              ssyn_q  <= 1'b0;
              d_out_q <= 16'd0;
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_busmem.sv
module tb_busmem;
  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        armwrite;
  logic [2:0]  armwaddr;
  logic [31:0] armwdata;
  logic [2:0]  armraddr;
  logic [31:0] armrdata;
  logic [17:0] a_in_h;
  logic [1:0]  c_in_h;
  logic [15:0] d_in_h;
  logic        msyn_in_h, init_in_h;
  logic [15:0] d_out_h;
  logic        ssyn_out_h;

  int checks = 0;
  int errors = 0;

  busmem dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .armwrite(armwrite), .armwaddr(armwaddr), .armwdata(armwdata),
    .armraddr(armraddr), .armrdata(armrdata),
    .a_in_h(a_in_h), .c_in_h(c_in_h), .d_in_h(d_in_h),
    .msyn_in_h(msyn_in_h), .init_in_h(init_in_h),
    .d_out_h(d_out_h), .ssyn_out_h(ssyn_out_h)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic        wr;
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  raddr;
    logic [31:0] exp;
  } arm_vec_t;

  arm_vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic arm_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge CLOCK);
    armwrite = 1'b1; armwaddr = a; armwdata = d;
    @(negedge CLOCK);
    armwrite = 1'b0;
  endtask

  task automatic arm_rd(input logic [2:0] a, output logic [31:0] d);
    armraddr = a;
    #1 d = armrdata;
  endtask

  // Runs one bus cycle; lat = clocks from first msyn sample to ssyn, -1 if none.
  task automatic bus_cycle(input logic [17:0] a, input logic [1:0] c, input logic [15:0] d,
                           output int lat, output logic [15:0] dout);
    logic [15:0] dmax;
    @(negedge CLOCK);
    a_in_h = a; c_in_h = c; d_in_h = d; msyn_in_h = 1'b1;
    lat = -1; dmax = 16'd0; dout = 16'd0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLOCK); #1;
      dmax = dmax | d_out_h;
      if (ssyn_out_h) begin
        lat = i; dout = d_out_h;
        break;
      end
    end
    if (lat < 0) dout = dmax;
    @(negedge CLOCK);
    msyn_in_h = 1'b0;
    repeat (2) @(negedge CLOCK);
  endtask

  logic [31:0] r, cnt_before;
  logic [15:0] dout;
  int lat;

  initial begin
    RESET = 1'b1; armwrite = 1'b0; armwaddr = 3'd0; armwdata = 32'd0; armraddr = 3'd0;
    a_in_h = 18'd0; c_in_h = 2'b00; d_in_h = 16'd0; msyn_in_h = 1'b0; init_in_h = 1'b0;
    repeat (3) @(negedge CLOCK);
    RESET = 1'b0;
    chk("reset_ssyn", {31'd0, ssyn_out_h}, 32'd0);
    chk("reset_dout", {16'd0, d_out_h}, 32'd0);

    vecs[0] = '{1'b0, 3'd0, 32'h0,        3'd0, 32'h424D2003};
    vecs[1] = '{1'b0, 3'd0, 32'h0,        3'd1, 32'h00000000};
    vecs[2] = '{1'b0, 3'd0, 32'h0,        3'd2, 32'h00000000};
    vecs[3] = '{1'b0, 3'd0, 32'h0,        3'd3, 32'h00000000};
    vecs[4] = '{1'b0, 3'd0, 32'h0,        3'd4, 32'hDEADBEEF};
    vecs[5] = '{1'b0, 3'd0, 32'h0,        3'd7, 32'hDEADBEEF};
    vecs[6] = '{1'b1, 3'd0, 32'hFFFFFFFF, 3'd0, 32'h424D2003};
    vecs[7] = '{1'b1, 3'd1, 32'hFFFFFFFF, 3'd1, 32'h8003E000};
    vecs[8] = '{1'b1, 3'd1, 32'h00002000, 3'd1, 32'h00002000};
    vecs[9] = '{1'b1, 3'd1, 32'h80000000, 3'd1, 32'h80000000};
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) arm_wr(vecs[i].waddr, vecs[i].wdata);
      arm_rd(vecs[i].raddr, r);
      chk($sformatf("armvec%0d", i), r, vecs[i].exp);
    end

    // Word write then read back, with latency and counters
    bus_cycle(18'o000100, 2'b10, 16'o123456, lat, dout);
    chk("dato_lat", lat, 32'd18);
    chk("dato_dout", {16'd0, dout}, 32'd0);
    bus_cycle(18'o000100, 2'b00, 16'd0, lat, dout);
    chk("dati_lat", lat, 32'd18);
    chk("dati_data", {16'd0, dout}, {16'd0, 16'o123456});
    arm_rd(3'd2, r);
    chk("counters_11", r, 32'h00010001);
    chk("ssyn_released", {31'd0, ssyn_out_h}, 32'd0);

    // Byte writes
    bus_cycle(18'o000200, 2'b10, 16'o012345, lat, dout);
    bus_cycle(18'o000201, 2'b11, 16'o177000, lat, dout);
    bus_cycle(18'o000200, 2'b01, 16'd0, lat, dout);
    chk("datob_high", {16'd0, dout}, {16'd0, 16'o177345});
    bus_cycle(18'o000200, 2'b11, 16'o000077, lat, dout);
    bus_cycle(18'o000200, 2'b00, 16'd0, lat, dout);
    chk("datob_low", {16'd0, dout}, {16'd0, 16'o177077});

    // Counter clear
    arm_wr(3'd2, 32'h0);
    arm_rd(3'd2, cnt_before);
    chk("counter_clear", cnt_before, 32'h0);

    // Non-matching windows
    arm_wr(3'd1, 32'h80002000);
    bus_cycle(18'o000100, 2'b00, 16'd0, lat, dout);
    chk("base1_nossyn", lat, -32'sd1);
    chk("base1_nodata", {16'd0, dout}, 32'd0);
    arm_wr(3'd1, 32'h8003E000);
    bus_cycle(18'o760100, 2'b00, 16'd0, lat, dout);
    chk("iopage_nossyn", lat, -32'sd1);
    arm_wr(3'd1, 32'h00000000);
    bus_cycle(18'o000100, 2'b00, 16'd0, lat, dout);
    chk("disabled_nossyn", lat, -32'sd1);
    arm_rd(3'd2, r);
    chk("nomatch_counters", r, 32'h0);
    arm_wr(3'd1, 32'h80000000);

    // ARM write request, busy then done
    arm_wr(3'd3, 32'h80051234);
    arm_rd(3'd3, r);
    chk("armwr_busy", r, 32'h80051234);
    @(negedge CLOCK);
    arm_rd(3'd3, r);
    chk("armwr_done", r, 32'h00051234);
    arm_wr(3'd3, 32'h40050000);
    repeat (2) @(negedge CLOCK);
    arm_rd(3'd3, r);
    chk("armrd_data", r, 32'h00051234);
    bus_cycle(18'o000012, 2'b00, 16'd0, lat, dout);
    chk("bus_sees_arm", {16'd0, dout}, 32'h00001234);

    // Write while busy is ignored
    @(negedge CLOCK);
    armwrite = 1'b1; armwaddr = 3'd3; armwdata = 32'h80075555;
    @(negedge CLOCK);
    armwdata = 32'h80096666;
    @(negedge CLOCK);
    armwrite = 1'b0;
    @(negedge CLOCK);
    arm_rd(3'd3, r);
    chk("busy_ignore", r, 32'h00075555);

    // Bus init during a DATO deskew aborts the write
    arm_wr(3'd2, 32'h0);
    @(negedge CLOCK);
    a_in_h = 18'o000100; c_in_h = 2'b10; d_in_h = 16'h0BAD; msyn_in_h = 1'b1;
    repeat (5) @(negedge CLOCK);
    init_in_h = 1'b1; msyn_in_h = 1'b0;
    @(negedge CLOCK);
    init_in_h = 1'b0;
    chk("init_ssyn", {31'd0, ssyn_out_h}, 32'd0);
    repeat (20) @(negedge CLOCK);
    chk("init_ssyn_late", {31'd0, ssyn_out_h}, 32'd0);
    arm_rd(3'd2, r);
    chk("init_counters", r, 32'h0);
    bus_cycle(18'o000100, 2'b00, 16'd0, lat, dout);
    chk("init_ram_kept", {16'd0, dout}, {16'd0, 16'o123456});

    // msyn dropped mid-deskew
    arm_wr(3'd2, 32'h0);
    @(negedge CLOCK);
    a_in_h = 18'o000100; c_in_h = 2'b10; d_in_h = 16'h0BAD; msyn_in_h = 1'b1;
    repeat (5) @(negedge CLOCK);
    msyn_in_h = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
        @(negedge CLOCK);
        seen = seen | ssyn_out_h;
      end
      chk("drop_nossyn", {31'd0, seen}, 32'd0);
    end
    arm_rd(3'd2, r);
    chk("drop_counters", r, 32'h0);
    bus_cycle(18'o000100, 2'b00, 16'd0, lat, dout);
    chk("drop_ram_kept", {16'd0, dout}, {16'd0, 16'o123456});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/busmem.md
BUSMEM -- requirements
Module: busmem

Interface
REQ-001 CLOCK  in  1  sole clock; all logic on rising edge.
REQ-002 RESET  in  1  synchronous, active-high reset.
REQ-003 armwrite in 1; armwaddr in 3; armwdata in 32: ARM register write strobe, address, data.
REQ-004 armraddr in 3; armrdata out 32: ARM register read address and combinational read data.
REQ-005 a_in_h in 18; c_in_h in 2; d_in_h in 16; msyn_in_h in 1; init_in_h in 1: Unibus inputs, true-high.
REQ-006 d_out_h out 16; ssyn_out_h out 1: Unibus slave outputs, true-high, registered.

Function
REQ-007 Internal RAM SHALL be 4096 x 16, one synchronous port, one-cycle read latency, byte write enables.
REQ-008 ARM reg 0 SHALL read 32'h424D2003 ('BM', 8 regs, version 003); writes ignored.
REQ-009 ARM reg 1 SHALL hold enable [31] and base [17:13] (8KB-aligned window); read back as written, other bits 0.
REQ-010 ARM reg 2 SHALL read {wrcount[31:16], rdcount[15:0]}; any write clears both; counters wrap 0xFFFF->0.
REQ-011 ARM reg 3 write SHALL latch armaddr[27:16] (12 bits) and armdata[15:0]; bit 31 = write request, bit 30 = read request; both set = write only.
REQ-012 ARM reg 3 read SHALL return {busy[31], 3'b0, armaddr[27:16], armdata[15:0]}; read request replaces armdata with RAM word.
REQ-013 Unregistered ARM addresses SHALL read 32'hDEADBEEF.
REQ-014 Match SHALL be enable & a_in_h[17:13]==base & base!=5'o37 (I/O page never served).
REQ-015 Bus FSM states: IDLE, DESKEW, ACCESS, REPLY, HOLD.
REQ-016 IDLE->DESKEW on msyn_in_h=1; counter cleared.
REQ-017 DESKEW SHALL count 16 clocks with msyn held; msyn drop returns to IDLE; at count 15, no match -> HOLD with ssyn 0, match -> ACCESS.
REQ-018 ACCESS (one clock): c=00/01 (DATI/DATIP) issue read at a_in_h[12:1]; c=10 write both bytes; c=11 write byte a_in_h[0] (1=high, 0=low).
REQ-019 REPLY SHALL, for reads, drive d_out_h with RAM data and ssyn_out_h=1 in same clock; writes assert ssyn only, d_out_h 0; increment matching counter once.
REQ-020 HOLD SHALL keep outputs until msyn_in_h=0, then clear ssyn_out_h and d_out_h next clock and return to IDLE.
REQ-021 Non-matching cycle SHALL never assert ssyn_out_h or drive d_out_h.
REQ-022 Bus-to-ssyn latency SHALL be 18 clocks from msyn rise.
REQ-023 ARM request SHALL execute in first clock FSM is not in ACCESS; busy set on latch, cleared when done; bus owns RAM in ACCESS.
REQ-024 ARM reg 3 write while busy SHALL be ignored.
REQ-025 ARM reg 1 changes mid-cycle SHALL take effect from next DESKEW decode; active cycle completes.

Reset
REQ-026 RESET SHALL clear enable, base, counters, busy, armaddr, armdata, d_out_h, ssyn_out_h; FSM->IDLE; RAM contents undefined.
REQ-027 init_in_h=1 SHALL clear d_out_h, ssyn_out_h, FSM->IDLE, abort write not past ACCESS; ARM regs and pending ARM request kept.
REQ-028 RESET and init same clock: RESET effects apply.

Structure
REQ-029 Package busmem_pkg SHALL hold FSM state enum, ident constant 32'h424D2003, Unibus c-code constants, deskew count 15.
REQ-030 One sub-module busmem_ram (4096x16, byte enables, sync read) SHALL be instantiated; FSM and ARM regs stay in busmem.

Verification
REQ-031 enable=1, base=0; DATO a=000100 d=123456 then DATI a=000100 -> d_out_h=123456, ssyn 18 clocks after msyn, wrcount=1, rdcount=1.
REQ-032 Word 012345 at 000200; DATOB a=000201 d=177000 -> DATI returns 177345; DATOB a=000200 d=000077 -> 177077.
REQ-033 base=1, DATI a=000100 -> ssyn never asserted, d_out_h 0, counters unchanged; base=37 any I/O-page address -> no response.
REQ-034 ARM reg3 write 0x8005_1234 -> busy then clear; ARM read 0x4005_0000 -> armdata 1234; bus DATI a=000012 -> 001234.
REQ-035 DATO in progress, init_in_h pulsed in DESKEW -> FSM IDLE, ssyn 0, RAM word unchanged.
REQ-036 msyn dropped at DESKEW count 5 -> no access, no ssyn, counters unchanged.
